// File: rtl/wb_stage.sv
// Writeback stage: dmem response wait/hold, load align/extend,
// register-file write, commit strobe and retire order.
package rv_pkg;

  typedef enum logic [2:0] {
    WB_ALU     = 3'd0,
    WB_BR      = 3'd1,
    WB_U_IMM   = 3'd2,
    WB_PC_NEXT = 3'd3,
    WB_MEM     = 3'd4
  } wb_sel_t;

  typedef struct packed {
    logic    regf_we;
    wb_sel_t wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic        valid_s;
    logic [31:0] inst_s;
    wb_ctrl_t    wb_ctrl_s;
    logic [4:0]  rd_s_s;
    logic        br_en_s;
    logic [31:0] alu_out_s;
    logic [31:0] mem_addr_s;
    logic [3:0]  mem_rmask_s;
    logic [3:0]  mem_wmask_s;
    logic [31:0] u_imm_s;
    logic [31:0] pc_next_s;
  } mem_wb_stage_reg_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

module wb_stage
  import rv_pkg::*;
#(
  parameter int ORDER_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               move,
  input  mem_wb_stage_reg_t  mem_wb_reg,
  input  logic               dmem_resp,
  input  logic [31:0]        dmem_rdata,
  output logic               dmem_stall,
  output logic               rd_we,
  output logic [4:0]         rd_sel,
  output logic [31:0]        rd_wdata,
  output logic               commit,
  output logic [ORDER_W-1:0] commit_order,
  output logic               resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        rdata_q;
  logic [ORDER_W-1:0] order_q;

  logic        valid;
  logic        memop;
  logic        is_load;
  logic        is_store;
  logic        retire;
  logic [2:0]  funct3;
  logic [1:0]  boff;
  logic [31:0] raw;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ld_data;
  logic [31:0] wdata;
  logic        unused_bits;

  assign valid   = mem_wb_reg.valid_s;
  assign funct3  = mem_wb_reg.inst_s[14:12];
  assign boff    = mem_wb_reg.mem_addr_s[1:0];

  assign memop = valid &&
    (mem_wb_reg.mem_rmask_s != 4'b0 ||
     mem_wb_reg.mem_wmask_s != 4'b0);

  assign is_load  = memop && mem_wb_reg.mem_rmask_s != 4'b0;
  assign is_store = memop && !is_load;

  assign dmem_stall = memop && !dmem_resp &&
    state_q != HELD;

  assign retire = valid && move && !dmem_stall;

  assign raw = (state_q == HELD) ? rdata_q : dmem_rdata;

  always_comb begin
    b = raw[7:0];
    unique case (boff)
      2'd0: b = raw[7:0];
      2'd1: b = raw[15:8];
      2'd2: b = raw[23:16];
      2'd3: b = raw[31:24];
      default: b = raw[7:0];
    endcase
  end

  assign h = boff[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    ld_data = 32'b0;
    unique case (funct3)
      F3_LB:   ld_data = {{24{b[7]}}, b};
      F3_LBU:  ld_data = {24'b0, b};
      F3_LH:   ld_data = {{16{h[15]}}, h};
      F3_LHU:  ld_data = {16'b0, h};
      F3_LW:   ld_data = raw;
      default: ld_data = 32'b0;
    endcase
  end

  always_comb begin
    wdata = 32'b0;
    unique case (mem_wb_reg.wb_ctrl_s.wb_sel)
      WB_ALU:     wdata = mem_wb_reg.alu_out_s;
      WB_BR:      wdata = {31'b0, mem_wb_reg.br_en_s};
      WB_U_IMM:   wdata = mem_wb_reg.u_imm_s;
      WB_PC_NEXT: wdata = mem_wb_reg.pc_next_s;
      WB_MEM:     wdata = ld_data;
      default:    wdata = 32'b0;
    endcase
  end

  // x0 and stores never reach the register file
  assign rd_we = retire &&
    mem_wb_reg.wb_ctrl_s.regf_we &&
    mem_wb_reg.rd_s_s != 5'd0 &&
    !is_store;

  assign rd_sel   = valid ? mem_wb_reg.rd_s_s : 5'd0;
  assign rd_wdata = valid ? wdata : 32'b0;

  assign commit       = retire;
  assign commit_order = order_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdata_q  <= 32'b0;
      order_q  <= '0;
      resp_err <= 1'b0;
    end else begin
      if (retire)
        order_q <= order_q + ORDER_W'(1);
      if (dmem_resp &&
          ((state_q == IDLE && !memop) ||
           state_q == HELD))
        resp_err <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (memop && !dmem_resp) begin
            state_q <= WAIT;
          end else if (memop && dmem_resp && !move) begin
            state_q <= HELD;
            rdata_q <= dmem_rdata;
          end
        end
        WAIT: begin
          if (dmem_resp) begin
            if (move) begin
              state_q <= IDLE;
            end else begin
              state_q <= HELD;
              rdata_q <= dmem_rdata;
            end
          end
        end
        HELD: begin
          if (move)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign unused_bits = ^{mem_wb_reg.inst_s[31:15],
                         mem_wb_reg.inst_s[11:0],
                         mem_wb_reg.mem_addr_s[31:2]};

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a commit scoreboard.
// Expected writebacks are queued at drive time, checked on commit.
module tb_wb_stage;
  import rv_pkg::*;

  localparam int OW = 8;

  logic              clk;
  logic              rst_n;
  logic              move;
  mem_wb_stage_reg_t m;
  logic              dmem_resp;
  logic [31:0]       dmem_rdata;
  logic              dmem_stall;
  logic              rd_we;
  logic [4:0]        rd_sel;
  logic [31:0]       rd_wdata;
  logic              commit;
  logic [OW-1:0]     commit_order;
  logic              resp_err;

  wb_stage #(.ORDER_W(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .move         (move),
    .mem_wb_reg   (m),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .dmem_stall   (dmem_stall),
    .rd_we        (rd_we),
    .rd_sel       (rd_sel),
    .rd_wdata     (rd_wdata),
    .commit       (commit),
    .commit_order (commit_order),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [4:0]    sel;
    logic [31:0]   d;
    logic [OW-1:0] ord;
  } exp_t;

  exp_t          sbq[$];
  logic [OW-1:0] exp_order;
  int            total;
  int            bad;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic we,
                      input logic [4:0] sel,
                      input logic [31:0] d);
    exp_t e;
    e.we  = we;
    e.sel = sel;
    e.d   = d;
    e.ord = exp_order;
    sbq.push_back(e);
    exp_order = exp_order + 1'b1;
  endtask

  function automatic mem_wb_stage_reg_t mk(
    input wb_sel_t     sel,
    input logic [4:0]  rd,
    input logic        we,
    input logic [3:0]  rmask,
    input logic [3:0]  wmask,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] alu,
    input logic        br,
    input logic [31:0] uimm,
    input logic [31:0] pcn);
    mem_wb_stage_reg_t r;
    r = '0;
    r.valid_s           = 1'b1;
    r.inst_s[14:12]     = f3;
    r.wb_ctrl_s.regf_we = we;
    r.wb_ctrl_s.wb_sel  = sel;
    r.rd_s_s            = rd;
    r.br_en_s           = br;
    r.alu_out_s         = alu;
    r.mem_addr_s        = addr;
    r.mem_rmask_s       = rmask;
    r.mem_wmask_s       = wmask;
    r.u_imm_s           = uimm;
    r.pc_next_s         = pcn;
    return r;
  endfunction

  function automatic mem_wb_stage_reg_t ld(
    input logic [2:0] f3,
    input logic [4:0] rd,
    input logic [31:0] addr);
    return mk(WB_MEM, rd, 1'b1, 4'hf, 4'h0, f3,
              addr, 32'h0, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic mem_wb_stage_reg_t op(
    input wb_sel_t sel,
    input logic [4:0] rd,
    input logic [31:0] alu,
    input logic br,
    input logic [31:0] uimm,
    input logic [31:0] pcn);
    return mk(sel, rd, 1'b1, 4'h0, 4'h0, 3'b000,
              32'h0, alu, br, uimm, pcn);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && commit) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_commit", 64'(commit), 64'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_rd_we", 64'(rd_we), 64'(e.we));
        chk("sb_rd_sel", 64'(rd_sel), 64'(e.sel));
        chk("sb_rd_wdata", 64'(rd_wdata), 64'(e.d));
        chk("sb_order", 64'(commit_order), 64'(e.ord));
      end
    end
  end

  initial begin
    logic [31:0] d;
    total      = 0;
    bad        = 0;
    exp_order  = '0;
    rst_n      = 1'b0;
    move       = 1'b0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    m          = '0;

    #12;
    chk("rst_stall", 64'(dmem_stall), 64'h0);
    chk("rst_we", 64'(rd_we), 64'h0);
    chk("rst_commit", 64'(commit), 64'h0);
    chk("rst_order", 64'(commit_order), 64'h0);
    chk("rst_err", 64'(resp_err), 64'h0);
    chk("rst_wdata", 64'(rd_wdata), 64'h0);
    step();
    rst_n = 1'b1;

    step();
    m = ld(F3_LW, 5'd5, 32'h100);
    move = 1'b0;
    smp();
    chk("lw_stall0", 64'(dmem_stall), 64'h1);
    chk("lw_nocommit0", 64'(commit), 64'h0);
    step();
    smp();
    chk("lw_stall1", 64'(dmem_stall), 64'h1);
    step();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hdeadbeef;
    move       = 1'b1;
    push(1'b1, 5'd5, 32'hdeadbeef);
    smp();
    chk("lw_resp_stall", 64'(dmem_stall), 64'h0);
    chk("lw_resp_commit", 64'(commit), 64'h1);

    step();
    m = ld(F3_LB, 5'd10, 32'h103);
    dmem_rdata = 32'h80000000;
    push(1'b1, 5'd10, 32'hffffff80);
    smp();
    chk("lb_stall", 64'(dmem_stall), 64'h0);
    step();
    m = ld(F3_LBU, 5'd11, 32'h103);
    push(1'b1, 5'd11, 32'h00000080);
    step();
    m = ld(F3_LH, 5'd12, 32'h102);
    dmem_rdata = 32'h7fff0000;
    push(1'b1, 5'd12, 32'h00007fff);
    step();
    m = ld(F3_LHU, 5'd13, 32'h102);
    dmem_rdata = 32'h80010000;
    push(1'b1, 5'd13, 32'h00008001);
    step();
    m = ld(F3_LH, 5'd14, 32'h100);
    dmem_rdata = 32'h0000c000;
    push(1'b1, 5'd14, 32'hffffc000);
    step();
    m = ld(F3_LB, 5'd15, 32'h101);
    dmem_rdata = 32'h00007f00;
    push(1'b1, 5'd15, 32'h0000007f);

    step();
    m = ld(F3_LW, 5'd6, 32'h200);
    dmem_rdata = 32'h12345678;
    move = 1'b0;
    smp();
    chk("held_stall0", 64'(dmem_stall), 64'h0);
    chk("held_nocommit0", 64'(commit), 64'h0);
    step();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'hcafef00d;
    smp();
    chk("held_stall1", 64'(dmem_stall), 64'h0);
    chk("held_nocommit1", 64'(commit), 64'h0);
    step();
    smp();
    chk("held_stall2", 64'(dmem_stall), 64'h0);
    step();
    move = 1'b1;
    push(1'b1, 5'd6, 32'h12345678);
    smp();
    chk("held_commit", 64'(commit), 64'h1);

    step();
    m = mk(WB_ALU, 5'd7, 1'b1, 4'h0, 4'hf, F3_LW,
           32'h104, 32'h104, 1'b0, 32'h0, 32'h0);
    move = 1'b0;
    smp();
    chk("sw_stall", 64'(dmem_stall), 64'h1);
    step();
    dmem_resp = 1'b1;
    move      = 1'b1;
    push(1'b0, 5'd7, 32'h104);
    smp();
    chk("sw_commit", 64'(commit), 64'h1);
    chk("sw_no_we", 64'(rd_we), 64'h0);
    step();
    dmem_resp = 1'b0;
    m = op(WB_ALU, 5'd0, 32'h55, 1'b0, 32'h0, 32'h0);
    push(1'b0, 5'd0, 32'h55);
    smp();
    chk("x0_stall", 64'(dmem_stall), 64'h0);
    step();
    m = op(WB_ALU, 5'd3, 32'h1234, 1'b0, 32'h0, 32'h0);
    push(1'b1, 5'd3, 32'h1234);
    step();
    m = op(WB_BR, 5'd4, 32'hffff, 1'b1, 32'h0, 32'h0);
    push(1'b1, 5'd4, 32'h1);
    step();
    m = op(WB_U_IMM, 5'd8, 32'h0, 1'b0, 32'habcde000, 32'h0);
    push(1'b1, 5'd8, 32'habcde000);
    step();
    m = op(WB_PC_NEXT, 5'd9, 32'h0, 1'b0, 32'h0, 32'h80000010);
    push(1'b1, 5'd9, 32'h80000010);

    step();
    m = '0;
    dmem_resp = 1'b1;
    smp();
    chk("inv_no_commit", 64'(commit), 64'h0);
    chk("inv_no_stall", 64'(dmem_stall), 64'h0);
    step();
    dmem_resp = 1'b0;
    smp();
    chk("err_set", 64'(resp_err), 64'h1);
    step();
    smp();
    chk("err_sticky", 64'(resp_err), 64'h1);
    step();
    m = ld(F3_LW, 5'd2, 32'h300);
    move = 1'b0;
    smp();
    chk("rst_wait_stall", 64'(dmem_stall), 64'h1);
    step();
    smp();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_err", 64'(resp_err), 64'h0);
    chk("arst_order", 64'(commit_order), 64'h0);
    exp_order = '0;
    m = '0;
    step();
    rst_n = 1'b1;
    step();
    dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    smp();
    chk("late_resp_err", 64'(resp_err), 64'h1);
    step();
    m = ld(F3_LW, 5'd2, 32'h300);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h0badf00d;
    move       = 1'b1;
    push(1'b1, 5'd2, 32'h0badf00d);
    smp();
    chk("post_rst_commit", 64'(commit), 64'h1);

    for (int i = 0; i < 300; i++) begin
      step();
      d = $urandom;
      m = ld(F3_LW, 5'd1, 32'h0);
      dmem_rdata = d;
      dmem_resp  = 1'b1;
      push(1'b1, 5'd1, d);
      smp();
      if (i % 50 == 0)
        chk("b2b_stall", 64'(dmem_stall), 64'h0);
    end

    step();
    m = '0;
    dmem_resp = 1'b0;
    step();
    smp();
    chk("sb_drained", 64'(sbq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32I pipeline, directly downstream of the data-memory port stage. It consumes the MEM/WB stage register and the data-memory response.
- Holds the pipeline (dmem_stall) until an outstanding load/store response returns, and captures response data if the pipeline cannot advance that cycle.
- Aligns and extends load data, selects the register-file write value, drives the register-file write port and forwarding value.
- Produces the commit strobe with a monotonically increasing retire order.

Parameters:
ORDER_W, 64, width of retire order counter (wraps modulo 2^ORDER_W)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
move  input  1  global pipeline advance from top; top guarantees move=0 while dmem_stall=1
mem_wb_reg  input  mem_wb_stage_reg_t  stage register; fields used: valid_s, inst_s (funct3=[14:12]), wb_ctrl_s (regf_we, wb_sel), rd_s_s, br_en_s, alu_out_s, mem_addr_s, mem_rmask_s, mem_wmask_s, u_imm_s, pc_next_s
dmem_resp  input  1  one-cycle response strobe for the outstanding dmem request
dmem_rdata  input  32  word-aligned read data, valid only with dmem_resp
dmem_stall  output  1  WB cannot retire this cycle
rd_we  output  1  register-file write enable
rd_sel  output  5  register-file write index
rd_wdata  output  32  register-file write data (also the forwarding value)
commit  output  1  instruction retires this cycle
commit_order  output  ORDER_W  order of retiring instruction
resp_err  output  1  sticky: dmem_resp seen with no memory op pending

Behaviour:
- Definitions:
  - memop = valid_s && (mem_rmask_s!=0 || mem_wmask_s!=0).
  - is_load = memop && mem_rmask_s!=0.
  - retire = valid_s && move && !dmem_stall.
- Reset (async, rst_n=0): state=IDLE, rdata_q=0, order_q=0, resp_err=0. Combinational outputs follow the rules below, so all are 0 when valid_s=0.
- FSM states:
  - IDLE: no response outstanding for the current instruction.
  - WAIT: memop present, response not yet received.
  - HELD: response received and captured in rdata_q, instruction not yet retired.
- FSM transitions:
  - IDLE: memop && !dmem_resp -> WAIT. memop && dmem_resp && !move -> HELD, capture dmem_rdata into rdata_q. Otherwise stay IDLE.
  - WAIT: dmem_resp && move -> IDLE (retire same cycle). dmem_resp && !move -> HELD, capture. No resp -> stay WAIT.
  - HELD: move -> IDLE. Ignore further dmem_resp in HELD and set resp_err.
- Stall and retire:
  - dmem_stall = memop && !dmem_resp && state!=HELD. This is combinational; a same-cycle response clears it, so there is zero added latency.
  - A response arriving in the first WB cycle retires in that cycle if move=1.
- Load data source:
  - raw = rdata_q in HELD, else dmem_rdata.
  - b = raw[8*mem_addr_s[1:0] +: 8]; h = raw[16*mem_addr_s[1] +: 16].
- Load extension by funct3:
  - lb: sign-extend b. lbu: zero-extend b.
  - lh: sign-extend h. lhu: zero-extend h.
  - lw: raw. Any other funct3: 0.
- Write data by wb_sel:
  - ALU: alu_out_s.
  - BR: {31'b0, br_en_s}.
  - U_IMM: u_imm_s.
  - PC_NEXT: pc_next_s.
  - MEM: load data.
- Register-file write:
  - rd_we = retire && regf_we && rd_s_s!=0 (x0 is never written).
  - Stores (wmask only) never write rd, regardless of regf_we.
  - rd_sel = rd_s_s; rd_wdata is driven whenever valid_s, even with rd_we=0.
- Commit and order:
  - commit = retire; commit_order = order_q.
  - order_q increments by 1 on each retire and wraps at 2^ORDER_W.
- resp_err is set on dmem_resp when state=IDLE && !memop, or when state=HELD. It clears only on reset.
- valid_s=0: no stall, no write, no commit; an IDLE state is not left.
- Reset mid-operation (WAIT/HELD): returns to IDLE and discards rdata_q. A late response arriving after reset with no memop sets resp_err.
- Back-to-back loads: the next instruction is seen only after retire, so each enters the FSM in IDLE.

Test Plan:
1. Reset, then lw rd=5, mem_addr_s=0x100, rmask=1111; dmem_resp two cycles later with 0xDEADBEEF, move=1 -> dmem_stall=1 for 2 cycles; rd_we=1, rd_wdata=0xDEADBEEF, commit=1, commit_order=0 on the resp cycle.
2. lb with mem_addr_s[1:0]=3, rdata=0x80000000 -> rd_wdata=0xFFFFFF80; lbu with same inputs -> 0x00000080; lh with addr[1]=1, rdata=0x7FFF0000 -> 0x00007FFF.
3. lw, resp arrives with move=0 (external stall) -> HELD, dmem_stall=0; dmem_rdata changes to garbage; move=1 two cycles later -> rd_wdata equals the captured value, then state=IDLE.
4. sw with rd field=7, regf_we=1, resp after 1 cycle -> rd_we=0, commit=1; addi rd=0 with regf_we=1 -> rd_we=0, commit=1; order advances 0->1->2.
5. dmem_resp pulse with valid_s=0 -> resp_err=1 and stays 1; rst_n low asynchronously while in WAIT -> state IDLE, order_q=0, resp_err=0 immediately.
6. 300 consecutive single-cycle-response lw instructions with ORDER_W=8 -> commit_order sequence wraps 255->0; no stall cycles when resp is same-cycle.
